// File: rtl/sunflower_pkg.sv
// Shared types and default widths for the sunflower mount scan logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sunflower_pkg;

   localparam int DEF_ADC_W   = 12;
   localparam int DEF_ANGLE_W = 8;

   typedef logic [DEF_ANGLE_W-1:0] angle_t;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      PARK_SETTLE,
      FINISH
   } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Load/decrement down-counter; expired is high while the count sits at zero.
// Latency: a load of N reports expired on the (N+1)th cycle after the load edge.
// Backpressure: none; load has priority over counting.
module scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   // Count down to zero and hold there until the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/sun_scan_controller.sv
// Raster-sweeps the theta/phi grid, samples the ADC at each point, tracks the peak, then parks there.
// Latency: first sample_req is 1+SETTLE_CYCLES cycles after start; done 1 cycle after park settling.
// Backpressure: waits on adc_valid per point up to TIMEOUT_CYCLES; abort exits to IDLE from any state.
module sun_scan_controller
   import sunflower_pkg::*;
#(
   parameter int ADC_W          = DEF_ADC_W,
   parameter int ANGLE_W        = DEF_ANGLE_W,
   parameter int THETA_MIN      = 0,
   parameter int THETA_MAX      = 180,
   parameter int PHI_MIN        = 0,
   parameter int PHI_MAX        = 90,
   parameter int STEP           = 10,
   parameter int SETTLE_CYCLES  = 50000,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [ADC_W-1:0]   adc_data,
   input  logic               adc_valid,
   output logic               sample_req,
   output logic [ANGLE_W-1:0] theta,
   output logic [ANGLE_W-1:0] phi,
   output logic               busy,
   output logic               done,
   output logic [ADC_W-1:0]   best_value,
   output logic [ANGLE_W-1:0] best_theta,
   output logic [ANGLE_W-1:0] best_phi,
   output logic               sample_err
);

   localparam int TMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0]      SETTLE_LD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]      TMO_LD    = TW'(TIMEOUT_CYCLES - 1);
   // One extra bit on the step sums so theta/phi near the top of the range cannot wrap.
   localparam logic [ANGLE_W:0]   STEP_X    = (ANGLE_W+1)'(STEP);
   localparam logic [ANGLE_W:0]   THETA_LIM = (ANGLE_W+1)'(THETA_MAX);
   localparam logic [ANGLE_W:0]   PHI_LIM   = (ANGLE_W+1)'(PHI_MAX);
   localparam logic [ANGLE_W-1:0] THETA_ORG = ANGLE_W'(THETA_MIN);
   localparam logic [ANGLE_W-1:0] PHI_ORG   = ANGLE_W'(PHI_MIN);

   scan_state_t        state, state_nxt;
   logic [ANGLE_W-1:0] theta_nxt, phi_nxt, best_theta_nxt, best_phi_nxt;
   logic [ADC_W-1:0]   best_value_nxt;
   logic               sample_err_nxt;
   logic               settle_load, tmo_load, settle_exp, tmo_exp;
   logic [ANGLE_W:0]   theta_sum, phi_sum;

   assign theta_sum = {1'b0, theta} + STEP_X;
   assign phi_sum   = {1'b0, phi} + STEP_X;

   scan_timer #(.W(TW)) u_settle_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (settle_load),
      .load_val (SETTLE_LD),
      .expired  (settle_exp)
   );

   scan_timer #(.W(TW)) u_timeout_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmo_load),
      .load_val (TMO_LD),
      .expired  (tmo_exp)
   );

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_nxt      = state;
      theta_nxt      = theta;
      phi_nxt        = phi;
      best_value_nxt = best_value;
      best_theta_nxt = best_theta;
      best_phi_nxt   = best_phi;
      sample_err_nxt = sample_err;
      settle_load    = 1'b0;
      tmo_load       = 1'b0;
      sample_req     = (state == SAMPLE);
      busy           = (state != IDLE);
      done           = (state == FINISH);

      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt      = SETTLE;
               theta_nxt      = THETA_ORG;
               phi_nxt        = PHI_ORG;
               best_value_nxt = '0;
               best_theta_nxt = THETA_ORG;
               best_phi_nxt   = PHI_ORG;
               sample_err_nxt = 1'b0;
               settle_load    = 1'b1;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (settle_exp) begin
               state_nxt = SAMPLE;
               tmo_load  = 1'b1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (adc_valid || tmo_exp) begin
               // A timed-out point counts as zero, so it can never become the best.
               if (adc_valid) begin
                  if (adc_data > best_value) begin
                     best_value_nxt = adc_data;
                     best_theta_nxt = theta;
                     best_phi_nxt   = phi;
                  end
               end else begin
                  sample_err_nxt = 1'b1;
               end
               settle_load = 1'b1;
               if (theta_sum <= THETA_LIM) begin
                  theta_nxt = theta_sum[ANGLE_W-1:0];
                  state_nxt = SETTLE;
               end else if (phi_sum <= PHI_LIM) begin
                  theta_nxt = THETA_ORG;
                  phi_nxt   = phi_sum[ANGLE_W-1:0];
                  state_nxt = SETTLE;
               end else begin
                  // Park on the best point including this final sample.
                  theta_nxt = best_theta_nxt;
                  phi_nxt   = best_phi_nxt;
                  state_nxt = PARK_SETTLE;
               end
            end
         end
         PARK_SETTLE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (settle_exp) begin
               state_nxt = FINISH;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         theta      <= THETA_ORG;
         phi        <= PHI_ORG;
         best_value <= '0;
         best_theta <= THETA_ORG;
         best_phi   <= PHI_ORG;
         sample_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         theta      <= theta_nxt;
         phi        <= phi_nxt;
         best_value <= best_value_nxt;
         best_theta <= best_theta_nxt;
         best_phi   <= best_phi_nxt;
         sample_err <= sample_err_nxt;
      end
   end

endmodule

// File: doc/sun_scan_controller.md
Name: sun_scan_controller

Overview:
- Sequences a raster sweep of the two-axis sunflower mount over a theta/phi grid.
- At each grid point it waits for the mechanics to settle, requests one ADC sample, and tracks the maximum voltage together with the angles where it occurred.
- After the sweep it parks the mount at the best point.
- Sits between the 12-bit ADC capture path and the servo angle drivers. Its best-value output feeds the BCD/7-segment display path.

Parameters:
- ADC_W, 12, ADC sample width
- ANGLE_W, 8, angle output width (degrees, unsigned)
- THETA_MIN, 0, first theta grid value
- THETA_MAX, 180, last allowed theta value (inclusive)
- PHI_MIN, 0, first phi grid value
- PHI_MAX, 90, last allowed phi value (inclusive)
- STEP, 10, grid increment for both axes, must be >0
- SETTLE_CYCLES, 50000, clk cycles waited after every angle change, must be ≥1
- TIMEOUT_CYCLES, 1000, max cycles sample_req waits for adc_valid

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy
- abort  in  1  level; stops a sweep, returns to IDLE
- adc_data  in  ADC_W  sample value, qualified by adc_valid
- adc_valid  in  1  one-cycle pulse, sample present
- sample_req  out  1  level, high while waiting for a sample
- theta  out  ANGLE_W  commanded theta angle
- phi  out  ANGLE_W  commanded phi angle
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when parking completes
- best_value  out  ADC_W  maximum sample of last/current sweep
- best_theta  out  ANGLE_W  theta at best_value
- best_phi  out  ANGLE_W  phi at best_value
- sample_err  out  1  sticky: at least one sample timed out this sweep

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; theta=THETA_MIN; phi=PHI_MIN.
  - sample_req, busy, done, best_value, sample_err = 0.
  - best_theta=THETA_MIN; best_phi=PHI_MIN.
  - A reset mid-sweep takes effect immediately; the sweep is not resumed.
- States: IDLE, SETTLE, SAMPLE, PARK_SETTLE, FINISH.
- IDLE:
  - Angles hold their last values.
  - On start, in the next cycle: theta=THETA_MIN, phi=PHI_MIN, best_value=0, best angles = grid origin, sample_err=0, state goes to SETTLE.
- SETTLE:
  - A timer loads SETTLE_CYCLES on entry. The state is left after exactly SETTLE_CYCLES cycles.
  - The first sample_req high cycle is cycle 1+SETTLE_CYCLES after the start cycle.
- SAMPLE:
  - sample_req is high for the whole state; timeout timer runs.
  - adc_valid is sampled only here; adc_valid outside SAMPLE is ignored.
  - On adc_valid: if adc_data > best_value (strict), update best_value, best_theta and best_phi from the current theta/phi. Ties keep the earlier point.
  - On timeout with no adc_valid: set sample_err, treat the point as value 0 (never updates best), and advance.
  - Advance rule:
    - If theta+STEP ≤ THETA_MAX: theta += STEP.
    - Else theta=THETA_MIN; then if phi+STEP ≤ PHI_MAX, phi += STEP; else the sweep is complete.
    - Compute with ANGLE_W+1 bits so wrap-around never aliases.
  - Not complete: go to SETTLE. Complete: theta←best_theta, phi←best_phi, go to PARK_SETTLE.
- PARK_SETTLE: waits SETTLE_CYCLES, then goes to FINISH.
- FINISH: done=1 for this single cycle; next state is IDLE. Angles remain parked.
- abort:
  - Has priority over every transition in any non-IDLE state.
  - Next state is IDLE; sample_req drops the next cycle; no done pulse.
  - Angles and best_* hold their values.
  - start in the same cycle as abort is ignored.
- Grid size = ((THETA_MAX−THETA_MIN)/STEP+1)×((PHI_MAX−PHI_MIN)/STEP+1) points. With the defaults this is 19×10 = 190.
- best_* outputs are registered and visible for the whole sweep. They remain valid after done until the next start.

Decomposition:
- sunflower_pkg holds:
  - the state enum (scan_state_t);
  - ADC_W and ANGLE_W default constants;
  - the angle typedef.
- One sub-module, scan_timer: a load/decrement down-counter with an expired flag. It is instantiated twice, once for settle and once for the sample timeout.

Test Plan (THETA 0..20, PHI 0..10, STEP 10, SETTLE_CYCLES 4, TIMEOUT_CYCLES 8 unless noted):
- Full sweep, ADC returns 100,300,200,50,300,10 at points (0,0),(10,0),(20,0),(0,10),(10,10),(20,10) -> best_value=300, best_theta=10, best_phi=0 (tie rejected); done pulses once; theta=10, phi=0 after done.
- Start at cycle 0 -> busy=1 from cycle 1; sample_req first high at cycle 5; theta/phi sequence (0,0),(10,0),(20,0),(0,10),(10,10),(20,10).
- No adc_valid at point (10,0), others 5 -> sample_err=1 after 8 wait cycles; sweep continues; best_value=5 at (0,0).
- abort asserted during the third SAMPLE -> IDLE next cycle, sample_req=0, no done, theta=20, phi=0 held; then start -> sweep restarts at (0,0) with best_value cleared.
- Async reset during SETTLE at point (0,10) -> all outputs reach their reset values without a clock edge; adc_valid pulses while IDLE are ignored.
- THETA_MAX=25, STEP=10 -> theta visits 0,10,20 only; start pulses while busy do not restart the sweep.
